sha256_msg_padder: RTL and testbench

- Initiator side of the SHA-256 core's message-word interface: accepts a raw big-endian 32-bit word stream and emits the FIPS 180-4 padded message as 512-bit blocks of 16 words.
- Appends 0x80, zero fill, and the 64-bit big-endian bit length, with block and message framing flags.
- Sits between the host-side FIFO and the sha2 core in `top`, so the core only ever sees whole padded blocks.

---
 rtl/sha256_msg_padder_if.sv | 26 ++
 rtl/sha256_msg_padder.sv | 146 ++++++++++++++
 tb/tb_sha256_msg_padder.sv | 218 +++++++++++++++++++++
 3 files changed

// File: rtl/sha256_msg_padder_if.sv
// Message-word stream between the host FIFO, the SHA-256 padder and the sha2 core.
// master = environment side (feeds raw words, sinks padded words); slave = the padder.
interface sha256_msg_padder_if;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic        in_last;
    logic [2:0]  in_bytes;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic        out_block_last;
    logic        out_msg_last;

    // Both streams: a word moves on a rising edge where valid && ready are high;
    // once valid is raised, data and flags stay stable until ready is seen.
    modport master (
        output in_valid, in_data, in_last, in_bytes, out_ready,
        input  in_ready, out_valid, out_data, out_block_last, out_msg_last
    );

    modport slave (
        input  in_valid, in_data, in_last, in_bytes, out_ready,
        output in_ready, out_valid, out_data, out_block_last, out_msg_last
    );
endinterface

// File: rtl/sha256_msg_padder.sv
// SHA-256 message padder: passes raw words through, then appends 0x80, zero fill
// and the 64-bit big-endian bit length so the core only sees whole 16-word blocks.
module sha256_msg_padder #(
    parameter int LEN_W = 64
) (
    input  logic                 refclk,
    input  logic                 rst,
    sha256_msg_padder_if.slave   bus,
    output logic [2:0]           dbg_state
);
    localparam int BW = LEN_W - 3;

    typedef enum logic [2:0] {
        ST_DATA   = 3'd0,
        ST_PAD80  = 3'd1,
        ST_ZERO   = 3'd2,
        ST_LEN_HI = 3'd3,
        ST_LEN_LO = 3'd4
    } state_t;

    state_t        state;
    logic [3:0]    widx;
    logic [BW-1:0] byte_cnt;
    logic          extra;

    logic [2:0]    k_last;
    logic [2:0]    k_add;
    logic [63:0]   bit_len;
    logic [31:0]   data_word;
    logic          out_valid;
    logic          in_ready;
    logic [31:0]   out_data;
    logic          out_hs;

    assign k_last  = (bus.in_bytes > 3'd4) ? 3'd4 : bus.in_bytes;
    assign k_add   = bus.in_last ? k_last : 3'd4;
    assign bit_len = 64'({byte_cnt, 3'b000});
    assign out_hs  = out_valid && bus.out_ready;

    always_comb begin
        data_word = bus.in_data;
        if (bus.in_last) begin
            case (k_last)
                3'd0:    data_word = 32'h8000_0000;
                3'd1:    data_word = {bus.in_data[31:24], 24'h80_0000};
                3'd2:    data_word = {bus.in_data[31:16], 16'h8000};
                3'd3:    data_word = {bus.in_data[31:8], 8'h80};
                default: data_word = bus.in_data;
            endcase
        end
    end

    always_comb begin
        out_valid = 1'b0;
        in_ready  = 1'b0;
        out_data  = 32'h0;
        if (!rst) begin
            case (state)
                ST_DATA: begin
                    out_valid = bus.in_valid;
                    in_ready  = bus.out_ready;
                    out_data  = data_word;
                end
                ST_PAD80: begin
                    out_valid = 1'b1;
                    out_data  = 32'h8000_0000;
                end
                ST_ZERO: begin
                    out_valid = 1'b1;
                end
                ST_LEN_HI: begin
                    out_valid = 1'b1;
                    out_data  = bit_len[63:32];
                end
                ST_LEN_LO: begin
                    out_valid = 1'b1;
                    out_data  = bit_len[31:0];
                end
                default: begin
                    out_valid = 1'b0;
                end
            endcase
        end
    end

    assign bus.out_valid      = out_valid;
    assign bus.in_ready       = in_ready;
    assign bus.out_data       = out_data;
    assign bus.out_block_last = out_valid && (widx == 4'd15);
    assign bus.out_msg_last   = out_valid && (state == ST_LEN_LO);
    assign dbg_state          = state;

    // Where to go after the word carrying 0x80 sits at index w. A 0x80 word at
    // index 15 already closes its block, so only w == 14 needs the extra block.
    function automatic state_t after_pad80(input logic [3:0] w);
        return (w == 4'd13) ? ST_LEN_HI : ST_ZERO;
    endfunction

    always_ff @(posedge refclk or posedge rst) begin
        if (rst) begin
            state    <= ST_DATA;
            widx     <= 4'd0;
            byte_cnt <= '0;
            extra    <= 1'b0;
        end else if (out_hs) begin
            widx <= widx + 4'd1;
            case (state)
                ST_DATA: begin
                    byte_cnt <= byte_cnt + BW'(k_add);
                    if (bus.in_last) begin
                        if (k_last == 3'd4) begin
                            state <= ST_PAD80;
                        end else begin
                            state <= after_pad80(widx);
                            extra <= (widx == 4'd14);
                        end
                    end
                end
                ST_PAD80: begin
                    state <= after_pad80(widx);
                    extra <= (widx == 4'd14);
                end
                ST_ZERO: begin
                    if (widx == 4'd15) begin
                        extra <= 1'b0;
                    end
                    if (widx == 4'd13 && !extra) begin
                        state <= ST_LEN_HI;
                    end
                end
                ST_LEN_HI: begin
                    state <= ST_LEN_LO;
                end
                ST_LEN_LO: begin
                    state    <= ST_DATA;
                    widx     <= 4'd0;
                    byte_cnt <= '0;
                    extra    <= 1'b0;
                end
                default: begin
                    state <= ST_DATA;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_sha256_msg_padder.sv
// Self-checking bench for sha256_msg_padder: a byte-level FIPS padding model
// fills an expected queue that the output monitor drains word by word.
module tb_sha256_msg_padder;
    logic       refclk;
    logic       rst;
    logic [2:0] dbg_state;
    int         checks;
    int         errors;
    int         bp_pct;

    // {pad word, msg_last, block_last, data}
    logic [34:0] exp_q[$];

    sha256_msg_padder_if bus ();

    sha256_msg_padder #(.LEN_W(64)) dut (
        .refclk    (refclk),
        .rst       (rst),
        .bus       (bus.slave),
        .dbg_state (dbg_state)
    );

    // ---------------- clock / reset ----------------
    initial refclk = 1'b0;
    always #5 refclk = ~refclk;

    // ---------------- checking ----------------
    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    // ---------------- sink ready (backpressure) ----------------
    initial begin
        bus.out_ready = 1'b1;
        forever begin
            @(posedge refclk);
            #1;
            bus.out_ready = (bp_pct > 0 && $urandom_range(0, 99) < bp_pct) ? 1'b0 : 1'b1;
        end
    end

    // ---------------- monitor / scoreboard ----------------
    initial begin
        logic        stalled_prev;
        logic [34:0] held;
        logic [34:0] head;
        stalled_prev = 1'b0;
        held = '0;
        forever begin
            @(negedge refclk);
            if (rst) begin
                stalled_prev = 1'b0;
            end else begin
                if (stalled_prev) begin
                    check_eq("hold", {bus.out_valid, bus.out_msg_last, bus.out_block_last, bus.out_data},
                             {1'b1, held[33:0]});
                end
                if (bus.out_valid) begin
                    if (exp_q.size() == 0) begin
                        check_eq("spurious_valid", bus.out_valid, 0);
                    end else begin
                        head = exp_q[0];
                        if (head[34]) check_eq("pad_in_ready", bus.in_ready, 0);
                        if (bus.out_ready) begin
                            void'(exp_q.pop_front());
                            check_eq("out_data", bus.out_data, head[31:0]);
                            check_eq("block_last", bus.out_block_last, head[32]);
                            check_eq("msg_last", bus.out_msg_last, head[33]);
                        end
                    end
                end
                stalled_prev = bus.out_valid && !bus.out_ready;
                held = {1'b0, bus.out_msg_last, bus.out_block_last, bus.out_data};
            end
        end
    end

    // ---------------- driver ----------------
    task automatic send_msg(input int n, input bit use_abc);
        logic [7:0]  mb[$];
        logic [7:0]  pb[$];
        logic [7:0]  abc_b[3];
        logic [63:0] bl;
        logic [31:0] word;
        logic [7:0]  b8;
        int          nw;
        int          npw;
        int          rem;
        int          cyc;
        bit          hs;
        abc_b = '{8'h61, 8'h62, 8'h63};
        for (int i = 0; i < n; i++) mb.push_back(use_abc ? abc_b[i] : 8'($urandom_range(0, 255)));
        // independent FIPS 180-4 model at byte level
        pb = mb;
        pb.push_back(8'h80);
        while ((pb.size() % 64) != 56) pb.push_back(8'h00);
        bl = 64'(n) * 64'd8;
        for (int i = 7; i >= 0; i--) pb.push_back(bl[i*8 +: 8]);
        nw  = (n == 0) ? 1 : (n + 3) / 4;
        npw = pb.size() / 4;
        for (int w = 0; w < npw; w++) begin
            word = {pb[w*4], pb[w*4+1], pb[w*4+2], pb[w*4+3]};
            exp_q.push_back({(w >= nw), (w == npw - 1), (w % 16 == 15), word});
        end
        for (int w = 0; w < nw; w++) begin
            word = '0;
            for (int b = 0; b < 4; b++) begin
                if (w*4 + b < n) b8 = mb[w*4 + b];
                else             b8 = use_abc ? 8'h00 : 8'($urandom_range(0, 255));
                word = {word[23:0], b8};
            end
            bus.in_valid = 1'b1;
            bus.in_data  = word;
            bus.in_last  = (w == nw - 1);
            rem = n - 4*w;
            if (w != nw - 1) bus.in_bytes = 3'($urandom_range(0, 7));
            else if (rem >= 4) bus.in_bytes = 3'($urandom_range(4, 7));
            else bus.in_bytes = 3'(rem);
            cyc = 0;
            do begin
                @(negedge refclk);
                hs = bus.in_ready;
                @(posedge refclk);
                cyc++;
            end while (!hs && cyc < 2000);
            if (!hs) check_eq("in_timeout", hs, 1);
            #1;
        end
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
    endtask

    task automatic wait_drain();
        int c;
        c = 0;
        while (exp_q.size() != 0 && c < 5000) begin
            @(posedge refclk);
            c++;
        end
        check_eq("drain", exp_q.size(), 0);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int c;
        checks   = 0;
        errors   = 0;
        bp_pct   = 0;
        rst      = 1'b1;
        bus.in_valid = 1'b0;
        bus.in_data  = '0;
        bus.in_last  = 1'b0;
        bus.in_bytes = '0;
        repeat (3) @(negedge refclk);
        check_eq("rst_out_valid", bus.out_valid, 0);
        check_eq("rst_in_ready", bus.in_ready, 0);
        check_eq("rst_out_data", bus.out_data, 0);
        check_eq("rst_block_last", bus.out_block_last, 0);
        check_eq("rst_msg_last", bus.out_msg_last, 0);
        #1 rst = 1'b0;
        @(negedge refclk);
        check_eq("idle_out_valid", bus.out_valid, 0);
        check_eq("idle_in_ready", bus.in_ready, 1);
        @(posedge refclk);
        #1;

        // abc, empty, 56 and 64 bytes back to back
        send_msg(3, 1'b1);
        send_msg(0, 1'b0);
        send_msg(56, 1'b0);
        send_msg(64, 1'b0);
        wait_drain();

        // 50% backpressure, lengths landing 0x80 at word 13, 14, 15 and across blocks
        bp_pct = 50;
        send_msg(3, 1'b1);
        send_msg(52, 1'b0);
        send_msg(55, 1'b0);
        send_msg(59, 1'b0);
        send_msg(60, 1'b0);
        send_msg(63, 1'b0);
        send_msg(130, 1'b0);
        wait_drain();
        bp_pct = 0;
        repeat (2) @(posedge refclk);
        #1;

        // reset mid-ZERO, then a clean abc
        send_msg(3, 1'b1);
        c = 0;
        while (exp_q.size() > 8 && c < 200) begin
            @(posedge refclk);
            c++;
        end
        check_eq("reach_zero", (exp_q.size() <= 8), 1);
        @(negedge refclk);
        #1 rst = 1'b1;
        exp_q.delete();
        @(negedge refclk);
        check_eq("mid_rst_out_valid", bus.out_valid, 0);
        check_eq("mid_rst_in_ready", bus.in_ready, 0);
        check_eq("mid_rst_msg_last", bus.out_msg_last, 0);
        #1 rst = 1'b0;
        @(posedge refclk);
        #1;
        send_msg(3, 1'b1);
        wait_drain();
        repeat (4) @(negedge refclk);
        check_eq("final_out_valid", bus.out_valid, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
